// File: rtl/mem_lsu_pkg.sv
// Shared opcodes, FSM states and the latched bus-request record for the MEM-stage LSU.
// Opcode values follow the existing AluOp encoding used by ex/ex_mem.
package mem_lsu_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic STOP      = 1'b1;
    localparam int   STALL_MEM = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    // Everything needed to hold the bus stable and finish alignment while BUSY.
    typedef struct packed {
        logic [7:0]  op;
        logic [1:0]  lo;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dbus_req_t;

    function automatic logic is_load(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic is_mem(input logic [7:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return lo[0];
            EXE_LW_OP, EXE_SW_OP:             return |lo;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus request/acknowledge channel between the LSU (master) and memory (slave).
// req is held with stable attributes until ack; ack carries rdata for loads.
interface mem_lsu_if;

    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req,
        output dbus_we,
        output dbus_sel,
        output dbus_addr,
        output dbus_wdata,
        input  dbus_ack,
        input  dbus_rdata
    );

    modport slave (
        input  dbus_req,
        input  dbus_we,
        input  dbus_sel,
        input  dbus_addr,
        input  dbus_wdata,
        output dbus_ack,
        output dbus_rdata
    );

endinterface

// File: rtl/mem_lsu_align.sv
// Big-endian lane logic: byte enables and store replication, plus load lane pick and extension.
// Purely combinational, no flow control.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  sel,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Address 0 is the most significant lane.
    always_comb begin
        case (addr_lo)
            2'b00:   ld_byte = ld_raw[31:24];
            2'b01:   ld_byte = ld_raw[23:16];
            2'b10:   ld_byte = ld_raw[15:8];
            default: ld_byte = ld_raw[7:0];
        endcase
        ld_half = addr_lo[1] ? ld_raw[15:0] : ld_raw[31:16];
    end

    always_comb begin
        sel      = 4'b0000;
        st_wdata = 32'h0000_0000;
        ld_data  = 32'h0000_0000;
        case (aluop)
            EXE_LB_OP: begin
                sel     = 4'b1000 >> addr_lo;
                ld_data = {{24{ld_byte[7]}}, ld_byte};
            end
            EXE_LBU_OP: begin
                sel     = 4'b1000 >> addr_lo;
                ld_data = {24'h00_0000, ld_byte};
            end
            EXE_LH_OP: begin
                sel     = addr_lo[1] ? 4'b0011 : 4'b1100;
                ld_data = {{16{ld_half[15]}}, ld_half};
            end
            EXE_LHU_OP: begin
                sel     = addr_lo[1] ? 4'b0011 : 4'b1100;
                ld_data = {16'h0000, ld_half};
            end
            EXE_LW_OP: begin
                sel     = 4'b1111;
                ld_data = ld_raw;
            end
            EXE_SB_OP: begin
                sel      = 4'b1000 >> addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            EXE_SH_OP: begin
                sel      = addr_lo[1] ? 4'b0011 : 4'b1100;
                st_wdata = {2{st_data[15:0]}};
            end
            EXE_SW_OP: begin
                sel      = 4'b1111;
                st_wdata = st_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one data-bus access per memory op and stalls IF..MEM until it ends.
// Load result reaches mem_wb the cycle after ack; holds in DONE while stall[3] is Stop.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [7:0]  i_aluop,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_reg2,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_wd,
    input  logic        i_wreg,
    input  logic        i_whilo,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [31:0] mem_wdata,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        stallreq,
    output logic        misalign,
    output logic        bus_err,
    mem_lsu_if.master   dbus
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        drop_q, drop_d;
    dbus_req_t   req_q, req_d;
    dbus_req_t   req_new, req_out;

    logic        in_idle, in_busy, in_done;
    logic        mem_op, mis_op, start, expire, finish;
    logic [7:0]  al_op;
    logic [1:0]  al_lo;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata, al_ldata;
    logic        unused_stall;

    assign unused_stall = ^{stall[5:4], stall[2:0]};

    always_comb begin
        in_idle = (state_q == ST_IDLE);
        in_busy = (state_q == ST_BUSY);
        in_done = (state_q == ST_DONE);
        mem_op  = is_mem(i_aluop);
        mis_op  = mem_op && is_misaligned(i_aluop, i_mem_addr[1:0]);
        // Reset gates the combinational request so req drops the moment rst_n falls.
        start   = rst_n && in_idle && mem_op && !mis_op && !flush;
        expire  = in_busy && !dbus.dbus_ack && (cnt_q == CNT_LAST);
        finish  = in_busy && (dbus.dbus_ack || (cnt_q == CNT_LAST));
        // While BUSY the lane logic works from the latched op so rdata is aligned correctly.
        al_op   = in_busy ? req_q.op : i_aluop;
        al_lo   = in_busy ? req_q.lo : i_mem_addr[1:0];
    end

    lsu_align u_align (
        .aluop    (al_op),
        .addr_lo  (al_lo),
        .st_data  (i_reg2),
        .ld_raw   (dbus.dbus_rdata),
        .sel      (al_sel),
        .st_wdata (al_wdata),
        .ld_data  (al_ldata)
    );

    always_comb begin
        req_new.op    = i_aluop;
        req_new.lo    = i_mem_addr[1:0];
        req_new.we    = is_store(i_aluop);
        req_new.sel   = al_sel;
        req_new.addr  = {i_mem_addr[31:2], 2'b00};
        req_new.wdata = al_wdata;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        drop_d  = drop_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    cnt_d   = 8'd0;
                    req_d   = req_new;
                    err_d   = 1'b0;
                    drop_d  = 1'b0;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // The access cannot be withdrawn once issued; remember to discard it.
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (dbus.dbus_ack) begin
                    rdata_d = al_ldata;
                    err_d   = 1'b0;
                end else if (expire) begin
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b1;
                end
                if (finish) begin
                    state_d = (drop_q || flush) ? ST_IDLE : ST_DONE;
                    cnt_d   = 8'd0;
                    drop_d  = 1'b0;
                    req_d   = '0;
                end
            end
            ST_DONE: begin
                if (flush || (stall[STALL_MEM] != STOP)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            req_q   <= req_d;
        end
    end

    assign req_out         = in_busy ? req_q : (start ? req_new : '0);
    assign dbus.dbus_req   = in_busy || start;
    assign dbus.dbus_we    = req_out.we;
    assign dbus.dbus_sel   = req_out.sel;
    assign dbus.dbus_addr  = req_out.addr;
    assign dbus.dbus_wdata = req_out.wdata;

    assign stallreq = start || in_busy;
    assign misalign = rst_n && in_idle && mis_op && !flush;
    assign bus_err  = expire;

    // Nothing commits to mem_wb while the stage is stalling on its own access.
    always_comb begin
        mem_wd    = i_wd;
        mem_hi    = i_hi;
        mem_lo    = i_lo;
        mem_wdata = (in_done && is_load(i_aluop)) ? rdata_q : i_wdata;
        mem_wreg  = i_wreg && !flush && !stallreq && !misalign && !(in_done && err_q);
        mem_whilo = i_whilo && !flush && !stallreq;
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: IDLE-cycle vector table, directed multi-cycle sequences and
// randomized accesses checked against a lane/extension model built from byte arithmetic.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam logic [7:0] NOP_OP = 8'b0010_0101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic [7:0]  i_aluop;
    logic [31:0] i_mem_addr, i_reg2, i_wdata, i_hi, i_lo;
    logic [4:0]  i_wd;
    logic        i_wreg, i_whilo;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo, stallreq, misalign, bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_lsu_if dbus ();

    mem_lsu #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .i_aluop    (i_aluop),
        .i_mem_addr (i_mem_addr),
        .i_reg2     (i_reg2),
        .i_wdata    (i_wdata),
        .i_wd       (i_wd),
        .i_wreg     (i_wreg),
        .i_whilo    (i_whilo),
        .i_hi       (i_hi),
        .i_lo       (i_lo),
        .mem_wdata  (mem_wdata),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_whilo  (mem_whilo),
        .mem_hi     (mem_hi),
        .mem_lo     (mem_lo),
        .stallreq   (stallreq),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .dbus       (dbus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model: access size in bytes, big-endian byte numbering ----
    function automatic int op_size(input logic [7:0] op);
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        return 4;
    endfunction

    function automatic bit op_store(input logic [7:0] op);
        return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
    endfunction

    function automatic bit op_signed(input logic [7:0] op);
        return op == EXE_LB_OP || op == EXE_LH_OP;
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [1:0] lo);
        int sz;
        logic [3:0] s;
        sz = op_size(op);
        s  = 4'b0000;
        for (int k = 0; k < sz; k++) s[3 - (int'(lo) + k)] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_ld(input logic [7:0] op, input logic [1:0] lo, input logic [31:0] rd);
        int sz;
        int sh;
        logic [31:0] v, mask;
        sz = op_size(op);
        sh = 8 * (4 - sz - int'(lo));
        v  = rd >> sh;
        if (sz < 4) begin
            mask = (32'h1 << (8 * sz)) - 32'h1;
            v    = v & mask;
            if (op_signed(op) && v[8 * sz - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] r2);
        int sz;
        sz = op_size(op);
        if (sz == 1) return {24'h0, r2[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'h0, r2[15:0]} * 32'h0001_0001;
        return r2;
    endfunction

    // Completes an access that is currently being requested from IDLE.
    task automatic drain();
        tick();
        dbus.dbus_ack   = 1'b1;
        dbus.dbus_rdata = 32'h0;
        tick();
        dbus.dbus_ack = 1'b0;
        i_aluop       = NOP_OP;
        flush         = 1'b0;
        tick();
    endtask

    // One full access from IDLE; ack arrives dly cycles after the request.
    task automatic txn(input string nm, input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] reg2, input int dly, input logic [31:0] rdata,
                       input logic [31:0] exp_ld);
        int n_stall;
        int bad;
        logic [3:0] esel;
        esel       = m_sel(op, addr[1:0]);
        i_aluop    = op;
        i_mem_addr = addr;
        i_reg2     = reg2;
        i_wreg     = !op_store(op);
        i_wdata    = $urandom;
        flush      = 1'b0;
        stall      = 6'b0;
        #1;
        chk({nm, "_sel"}, 32'(dbus.dbus_sel), 32'(esel));
        chk({nm, "_we"}, 32'(dbus.dbus_we), 32'(op_store(op)));
        if (op_store(op)) chk({nm, "_wdata"}, dbus.dbus_wdata, m_wdata(op, reg2));
        n_stall = stallreq ? 1 : 0;
        bad     = 0;
        for (int c = 1; c <= dly; c++) begin
            tick();
            if (c == dly) begin
                dbus.dbus_ack   = 1'b1;
                dbus.dbus_rdata = rdata;
            end
            #1;
            if (stallreq) n_stall++;
            if (!dbus.dbus_req || dbus.dbus_sel !== esel ||
                dbus.dbus_addr !== {addr[31:2], 2'b00} || mem_wreg) bad++;
        end
        chk({nm, "_stall_cycles"}, 32'(n_stall), 32'(dly + 1));
        chk({nm, "_busy_held"}, 32'(bad), 32'd0);
        tick();
        dbus.dbus_ack   = 1'b0;
        dbus.dbus_rdata = $urandom;
        #1;
        chk({nm, "_done_stall"}, 32'(stallreq), 32'd0);
        chk({nm, "_done_req"}, 32'(dbus.dbus_req), 32'd0);
        chk({nm, "_done_wdata"}, mem_wdata, op_store(op) ? i_wdata : exp_ld);
        chk({nm, "_done_wreg"}, 32'(mem_wreg), 32'(!op_store(op)));
        tick();
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic        fl;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_wdata;
        logic        e_mis;
        logic        e_wreg;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];
    logic [7:0] ops[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_err;
        logic [7:0]  rop;
        logic [31:0] raddr, rrd;

        vt[0]  = '{NOP_OP,     32'h100, 32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1};
        vt[1]  = '{EXE_LW_OP,  32'h100, 32'h0,         1'b0, 1'b1, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0};
        vt[2]  = '{EXE_LB_OP,  32'h103, 32'h0,         1'b0, 1'b1, 1'b0, 4'h1, 32'h0,         1'b0, 1'b0};
        vt[3]  = '{EXE_LBU_OP, 32'h101, 32'h0,         1'b0, 1'b1, 1'b0, 4'h4, 32'h0,         1'b0, 1'b0};
        vt[4]  = '{EXE_LH_OP,  32'h102, 32'h0,         1'b0, 1'b1, 1'b0, 4'h3, 32'h0,         1'b0, 1'b0};
        vt[5]  = '{EXE_LHU_OP, 32'h100, 32'h0,         1'b0, 1'b1, 1'b0, 4'hC, 32'h0,         1'b0, 1'b0};
        vt[6]  = '{EXE_SB_OP,  32'h201, 32'h11223344,  1'b0, 1'b1, 1'b1, 4'h4, 32'h44444444,  1'b0, 1'b0};
        vt[7]  = '{EXE_SH_OP,  32'h202, 32'h1234ABCD,  1'b0, 1'b1, 1'b1, 4'h3, 32'hABCDABCD,  1'b0, 1'b0};
        vt[8]  = '{EXE_SW_OP,  32'h204, 32'h0A0B0C0D,  1'b0, 1'b1, 1'b1, 4'hF, 32'h0A0B0C0D,  1'b0, 1'b0};
        vt[9]  = '{EXE_LW_OP,  32'h101, 32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         1'b1, 1'b0};
        vt[10] = '{EXE_SH_OP,  32'h201, 32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         1'b1, 1'b0};
        vt[11] = '{EXE_LHU_OP, 32'h103, 32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         1'b1, 1'b0};
        vt[12] = '{EXE_LW_OP,  32'h102, 32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         1'b1, 1'b0};
        vt[13] = '{EXE_LW_OP,  32'h100, 32'h0,         1'b1, 1'b0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b0};
        vt[14] = '{NOP_OP,     32'h100, 32'h0,         1'b1, 1'b0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b0};
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

        // Reset with an aligned load presented: nothing may leave the unit.
        rst_n = 1'b0; stall = 6'b0; flush = 1'b0;
        i_aluop = EXE_LW_OP; i_mem_addr = 32'h100; i_reg2 = 32'h0; i_wdata = 32'h0;
        i_wd = 5'd3; i_wreg = 1'b1; i_whilo = 1'b0; i_hi = 32'h0; i_lo = 32'h0;
        dbus.dbus_ack = 1'b0; dbus.dbus_rdata = 32'h0;
        #3;
        chk("rst_req", 32'(dbus.dbus_req), 32'd0);
        chk("rst_sel", 32'(dbus.dbus_sel), 32'd0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        i_aluop = NOP_OP;
        #9 rst_n = 1'b1;
        tick();

        for (int k = 0; k < NV; k++) begin
            i_aluop = vt[k].op; i_mem_addr = vt[k].addr; i_reg2 = vt[k].reg2;
            flush = vt[k].fl; i_wreg = 1'b1; i_wdata = 32'hCAFE_0000 + 32'(k);
            #1;
            chk($sformatf("vec%0d_req", k), 32'(dbus.dbus_req), 32'(vt[k].e_req));
            chk($sformatf("vec%0d_stallreq", k), 32'(stallreq), 32'(vt[k].e_req));
            chk($sformatf("vec%0d_misalign", k), 32'(misalign), 32'(vt[k].e_mis));
            chk($sformatf("vec%0d_wreg", k), 32'(mem_wreg), 32'(vt[k].e_wreg));
            chk($sformatf("vec%0d_sel", k), 32'(dbus.dbus_sel), 32'(vt[k].e_sel));
            chk($sformatf("vec%0d_we", k), 32'(dbus.dbus_we), 32'(vt[k].e_we));
            chk($sformatf("vec%0d_addr", k), dbus.dbus_addr, vt[k].e_req ? (vt[k].addr & ~32'h3) : 32'h0);
            chk($sformatf("vec%0d_mem_wdata", k), mem_wdata, 32'hCAFE_0000 + 32'(k));
            if (vt[k].e_we) chk($sformatf("vec%0d_wdata", k), dbus.dbus_wdata, vt[k].e_wdata);
            if (vt[k].e_req) drain(); else tick();
        end
        flush = 1'b0;

        txn("lw",  EXE_LW_OP,  32'h100, 32'h0,        3, 32'hDEADBEEF, 32'hDEADBEEF);
        txn("lb",  EXE_LB_OP,  32'h103, 32'h0,        1, 32'h000000F0, 32'hFFFFFFF0);
        txn("lbu", EXE_LBU_OP, 32'h103, 32'h0,        2, 32'h000000F0, 32'h000000F0);
        txn("sh",  EXE_SH_OP,  32'h202, 32'h1234ABCD, 2, 32'h0,        32'h0);

        // Timeout: no ack ever arrives.
        i_aluop = EXE_LW_OP; i_mem_addr = 32'h400; i_wreg = 1'b1;
        #1;
        first_err = -1;
        for (int c = 1; c <= 20; c++) begin
            tick(); #1;
            if (bus_err) begin
                first_err = c;
                break;
            end
        end
        chk("to_bus_err_cycle", 32'(first_err), 32'd16);
        tick(); #1;
        chk("to_done_wreg", 32'(mem_wreg), 32'd0);
        chk("to_done_stallreq", 32'(stallreq), 32'd0);
        chk("to_bus_err_pulse", 32'(bus_err), 32'd0);
        i_aluop = NOP_OP;
        tick(); #1;
        chk("to_idle_stallreq", 32'(stallreq), 32'd0);

        // Flush while BUSY, ack two cycles later: must return to IDLE, not DONE.
        i_aluop = EXE_LW_OP; i_mem_addr = 32'h300; i_wreg = 1'b1;
        #1;
        tick(); flush = 1'b1; #1;
        chk("fl_req_held", 32'(dbus.dbus_req), 32'd1);
        tick(); flush = 1'b0; #1;
        tick(); dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'h55; #1;
        tick(); dbus.dbus_ack = 1'b0; #1;
        chk("fl_no_done_stallreq", 32'(stallreq), 32'd1);
        chk("fl_no_done_wreg", 32'(mem_wreg), 32'd0);
        drain();

        // DONE holds under stall[3]; ack there is ignored; flush in DONE kills the write.
        i_aluop = EXE_LH_OP; i_mem_addr = 32'h102; i_wreg = 1'b1;
        #1;
        tick(); dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'h0000_8001; #1;
        tick(); dbus.dbus_ack = 1'b0; stall = 6'b001000; #1;
        tick(); dbus.dbus_ack = 1'b1; #1;
        chk("hold_wdata", mem_wdata, 32'hFFFF8001);
        chk("hold_wreg", 32'(mem_wreg), 32'd1);
        chk("hold_req", 32'(dbus.dbus_req), 32'd0);
        dbus.dbus_ack = 1'b0; flush = 1'b1; #1;
        chk("done_flush_wreg", 32'(mem_wreg), 32'd0);
        tick(); flush = 1'b0; stall = 6'b0; i_aluop = NOP_OP; #1;
        chk("done_flush_idle", 32'(stallreq), 32'd0);

        // Async reset in the middle of an access.
        i_aluop = EXE_LW_OP; i_mem_addr = 32'h500;
        #1;
        tick(); #1;
        chk("rstb_req_busy", 32'(dbus.dbus_req), 32'd1);
        rst_n = 1'b0; #1;
        chk("rstb_req_drop", 32'(dbus.dbus_req), 32'd0);
        chk("rstb_stallreq", 32'(stallreq), 32'd0);
        i_aluop = NOP_OP;
        tick(); #1 rst_n = 1'b1;
        tick(); #1;
        chk("rstb_idle_req", 32'(dbus.dbus_req), 32'd0);
        tick();

        for (int n = 0; n < 40; n++) begin
            rop   = ops[$urandom_range(0, 7)];
            raddr = $urandom;
            if (op_size(rop) == 2) raddr[0] = 1'b0;
            if (op_size(rop) == 4) raddr[1:0] = 2'b00;
            rrd = $urandom;
            txn($sformatf("rnd%0d", n), rop, raddr, $urandom, int'($urandom_range(1, 5)),
                rrd, m_ld(rop, raddr[1:0], rrd));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
